// File: rtl/apb_pkg.sv
// Shared types and constants for the parametrised APB4 master.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    localparam logic APB_RD = 1'b0;
    localparam logic APB_WR = 1'b1;

    // Width of the slave-select field at the top of the address.
    function automatic int sel_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 0;
    endfunction

    // Width of a slave index signal; never zero so it can always be declared.
    function automatic int idx_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_param_master_if.sv
// Command/response port plus APB fabric signals of apb_param_master, bundled as one interface.
interface apb_param_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_write_i;
    logic [ADDR_W-1:0]         cmd_addr_i;
    logic [DATA_W-1:0]         cmd_wdata_i;
    logic [DATA_W/8-1:0]       cmd_strb_i;
    logic                      rsp_valid_o;
    logic [DATA_W-1:0]         rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic [ADDR_W-1:0]         paddr_o;
    logic [NUM_SLV-1:0]        psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [DATA_W-1:0]         pwdata_o;
    logic [DATA_W/8-1:0]       pstrb_o;
    logic [NUM_SLV*DATA_W-1:0] prdata_i;
    logic [NUM_SLV-1:0]        pready_i;
    logic [NUM_SLV-1:0]        pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
               prdata_i, pready_i, pslverr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
               prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: top address bits -> one-hot select, index and decode error.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int NUM_SLV = 4,
    localparam int SEL_W   = sel_width(NUM_SLV),
    localparam int IDX_W   = idx_width(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [NUM_SLV-1:0] o_sel,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_dec_err
);
    logic [IDX_W-1:0] w_field;

    if (SEL_W == 0) begin : g_single
        assign w_field = '0;
        logic w_unused_addr;
        assign w_unused_addr = ^i_addr;
    end else begin : g_multi
        assign w_field = i_addr[ADDR_W-1 -: SEL_W];
        if (ADDR_W > SEL_W) begin : g_low
            logic w_unused_low;
            assign w_unused_low = ^i_addr[ADDR_W-SEL_W-1:0];
        end
    end

    always_comb begin
        o_sel     = '0;
        o_idx     = w_field;
        o_dec_err = ({1'b0, w_field} >= (IDX_W + 1)'(NUM_SLV));
        if (!o_dec_err) begin
            o_sel[w_field] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_param_master.sv
// APB4 master for NUM_SLV slaves: valid/ready command in, one response pulse out per command.
module apb_param_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               pclk,
    input  logic               preset_n,
    apb_param_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_SLV);
    localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    apb_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic                r_write;
    logic [NUM_SLV-1:0]  r_sel;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    logic [NUM_SLV-1:0]  w_dec_sel;
    logic [IDX_W-1:0]    w_dec_idx;
    logic                w_dec_err;
    logic                w_pready;
    logic                w_pslverr;
    logic [DATA_W-1:0]   w_prdata;
    logic                w_accept;
    logic                w_done;
    logic                w_abort;
    logic [CNT_W-1:0]    w_cnt_nxt;

    apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_decode (
        .i_addr    (bus.cmd_addr_i),
        .o_sel     (w_dec_sel),
        .o_idx     (w_dec_idx),
        .o_dec_err (w_dec_err)
    );

    // Only the selected slave's return signals are seen by the FSM.
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_pready  = bus.pready_i[k];
                w_pslverr = bus.pslverr_i[k];
                w_prdata  = bus.prdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            APB_IDLE: begin
                if (bus.cmd_valid_i) begin
                    w_accept = 1'b1;
                    if (!w_dec_err) w_state_nxt = APB_SETUP;
                end
            end
            APB_SETUP:  w_state_nxt = APB_ACCESS;
            APB_ACCESS: begin
                // A late PREADY beats the timeout on the same edge.
                if (w_pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = APB_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYC))) begin
                    w_abort     = 1'b1;
                    w_state_nxt = APB_IDLE;
                end
            end
            default:    w_state_nxt = APB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) r_state <= APB_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_strb        <= '0;
            r_write       <= APB_RD;
            r_sel         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;

            if (w_accept && w_dec_err) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
            end else if (w_accept) begin
                r_addr  <= bus.cmd_addr_i;
                r_write <= bus.cmd_write_i;
                r_wdata <= (bus.cmd_write_i == APB_WR) ? bus.cmd_wdata_i : '0;
                r_strb  <= (bus.cmd_write_i == APB_WR) ? bus.cmd_strb_i  : '0;
                r_sel   <= w_dec_sel;
                r_idx   <= w_dec_idx;
            end

            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= (r_write == APB_WR) ? '0 : w_prdata;
                r_rsp_err   <= w_pslverr;
            end

            if (w_abort) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end

            if (r_state == APB_SETUP)                     r_cnt <= '0;
            else if (r_state == APB_ACCESS && !w_pready)  r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.cmd_ready_o   = (r_state == APB_IDLE);
    assign bus.psel_o        = (r_state != APB_IDLE) ? r_sel : '0;
    assign bus.penable_o     = (r_state == APB_ACCESS);
    assign bus.paddr_o       = r_addr;
    assign bus.pwrite_o      = r_write;
    assign bus.pwdata_o      = r_wdata;
    assign bus.pstrb_o       = r_strb;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;

endmodule
